uart_tx_drain: RTL and testbench

Serial transmit stage that sits directly downstream of the synchronous FIFO. It pops bytes from the FIFO whenever the FIFO is non-empty and serialises each byte onto a single UART line. The frame format is 8N1, or 8E1 when parity is compiled in. It never reads an empty FIFO, so it cannot cause FIFO UnderFlow. It is the consumer that drains the FIFO's Data_OUT toward an off-chip link.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_gen.sv | 31 +++
 rtl/uart_tx_drain.sv | 136 +++++++++++++
 tb/tb_uart_tx_drain.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default baud divisor and line levels.
package uart_pkg;

   localparam int CLKS_PER_BIT_DEFAULT = 434;

   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;
   localparam logic IDLE_LVL  = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_POP    = 3'd1,
      S_LOAD   = 3'd2,
      S_START  = 3'd3,
      S_DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd5,
`endif
      S_STOP   = 3'd6
   } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the final cycle of each bit.
// The clear input holds the count at zero so the next period starts aligned.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic bit_tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear || (count == LAST)) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign bit_tick = !clear && (count == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// FIFO-draining UART transmitter, 8N1 by default, 8E1 when UART_TX_PARITY_EN is defined.
// Start bit 3 cycles after FIFO non-empty; pops only from IDLE with Empty low, so never underflows.
module uart_tx_drain
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  FIFO_Empty,
   input  logic [DATA_WIDTH-1:0] FIFO_Data,
   output logic                  FIFO_Read_EN,
   output logic                  TX,
   output logic                  Busy,
   output logic                  Frame_Done
);

   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   tx_state_t             state;
   logic [DATA_WIDTH-1:0] shift;
   logic [BW-1:0]         bit_cnt;
   logic                  baud_clr;
   logic                  bit_tick;
   logic                  next_lsb;
`ifdef UART_TX_PARITY_EN
   logic                  parity;
`endif

   // Counter is held at zero until the start bit so every bit period is exactly CLKS_PER_BIT.
   assign baud_clr = (state == S_IDLE) || (state == S_POP) || (state == S_LOAD);

   generate
      if (DATA_WIDTH > 1) begin : g_wide
         assign next_lsb = shift[1];
      end else begin : g_narrow
         assign next_lsb = STOP_LVL;
      end
   endgenerate

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (baud_clr),
      .bit_tick(bit_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         shift        <= '0;
         bit_cnt      <= '0;
         TX           <= IDLE_LVL;
         FIFO_Read_EN <= 1'b0;
         Busy         <= 1'b0;
         Frame_Done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity       <= 1'b0;
`endif
      end else begin
         FIFO_Read_EN <= 1'b0;
         Frame_Done   <= 1'b0;
         case (state)
            S_IDLE: begin
               TX <= IDLE_LVL;
               if (!FIFO_Empty) begin
                  state        <= S_POP;
                  FIFO_Read_EN <= 1'b1;
                  Busy         <= 1'b1;
               end
            end
            S_POP: begin
               state <= S_LOAD;
            end
            S_LOAD: begin
               // FIFO_Data is valid here, one cycle after the read strobe.
               shift   <= FIFO_Data;
               bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
               parity  <= ^FIFO_Data;
`endif
               TX      <= START_LVL;
               state   <= S_START;
            end
            S_START: begin
               if (bit_tick) begin
                  TX    <= shift[0];
                  state <= S_DATA;
               end
            end
            S_DATA: begin
               if (bit_tick) begin
                  shift   <= shift >> 1;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                     TX    <= parity;
                     state <= S_PARITY;
`else
                     TX    <= STOP_LVL;
                     state <= S_STOP;
`endif
                  end else begin
                     TX <= next_lsb;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (bit_tick) begin
                  TX    <= STOP_LVL;
                  state <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               if (bit_tick) begin
                  Busy       <= 1'b0;
                  Frame_Done <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            default: begin
               TX    <= IDLE_LVL;
               Busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: behavioural 32-deep FIFO feeding the DUT, serial-line monitor with scoreboard.
module tb_uart_tx_drain;

   localparam int DW  = 8;
   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
   localparam logic [NB-1:0] A5_BITS  = 11'b101_0100_1010;
   localparam logic [NB-1:0] B07_BITS = 11'b110_0000_1110;
`else
   localparam int NB = 10;
   localparam logic [NB-1:0] A5_BITS  = 10'b11_0100_1010;
   localparam logic [NB-1:0] B07_BITS = 10'b10_0000_1110;
`endif
   localparam int LATENCY = 3;
   // Start bit lands in the 4th cycle counting the Frame_Done cycle itself.
   localparam int B2B_GAP = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          FIFO_Empty;
   logic [DW-1:0] FIFO_Data = '0;
   logic          FIFO_Read_EN;
   logic          TX;
   logic          Busy;
   logic          Frame_Done;

   always #5 clk = ~clk;

   uart_tx_drain #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .FIFO_Empty  (FIFO_Empty),
      .FIFO_Data   (FIFO_Data),
      .FIFO_Read_EN(FIFO_Read_EN),
      .TX          (TX),
      .Busy        (Busy),
      .Frame_Done  (Frame_Done)
   );

   // Synchronous FIFO model; not reset by rst_n so its contents survive a DUT reset.
   logic [DW-1:0] mem [32];
   int            wp = 0, rp = 0, fcount = 0;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          underflow = 1'b0;
   logic          wr_ok, rd_ok;

   assign FIFO_Empty = (fcount == 0);
   assign wr_ok = wr_en && (fcount < 32);
   assign rd_ok = FIFO_Read_EN && (fcount != 0);

   always @(posedge clk) begin
      if (wr_ok) begin
         mem[wp] <= wr_data;
         wp <= (wp + 1) % 32;
      end
      if (FIFO_Read_EN && (fcount == 0)) underflow <= 1'b1;
      if (rd_ok) begin
         FIFO_Data <= mem[rp];
         rp <= (rp + 1) % 32;
      end
      fcount <= fcount + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
   end

   int vectors = 0, miscompares = 0;
   int frame_cnt = 0, rd_pulses = 0, done_pulses = 0;
   logic [DW-1:0] sb_q [$];
   bit mon_en = 1'b1;
   logic [NB-1:0] last_bits = '0;

   always @(negedge clk) begin
      if (FIFO_Read_EN === 1'b1) rd_pulses++;
      if (Frame_Done === 1'b1) done_pulses++;
   end

   // Line monitor: every sample of every bit period is checked against the scoreboard byte.
   logic [NB-1:0] m_want, m_got;
   logic [DW-1:0] m_v;
   bit            m_bad;
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && (rst_n === 1'b1) && (TX === 1'b0)) begin
            if (sb_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL frame_unexpected: start bit seen, scoreboard empty, required no frame");
               m_v = '0;
            end else begin
               m_v = sb_q.pop_front();
            end
`ifdef UART_TX_PARITY_EN
            m_want = {1'b1, ^m_v, m_v, 1'b0};
`else
            m_want = {1'b1, m_v, 1'b0};
`endif
            m_bad = 1'b0;
            m_got = '0;
            for (int b = 0; b < NB; b++) begin
               for (int c = 0; c < CPB; c++) begin
                  if (!(b == 0 && c == 0)) @(negedge clk);
                  if (TX !== m_want[b]) m_bad = 1'b1;
                  if (Frame_Done !== 1'b0) m_bad = 1'b1;
                  if (c == CPB / 2) m_got[b] = TX;
               end
            end
            @(negedge clk);
            vectors++;
            if (m_bad) begin
               miscompares++;
               $display("FAIL frame_bits: byte %h got %b required %b", m_v, m_got, m_want);
            end
            vectors++;
            if (Frame_Done !== 1'b1) begin
               miscompares++;
               $display("FAIL frame_done_timing: Frame_Done=%b %0d cycles after start, required 1", Frame_Done, NB * CPB);
            end
            last_bits = m_got;
            frame_cnt++;
         end
      end
   end

   task automatic push(input logic [DW-1:0] v, input bit track);
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = v;
      if (track) sb_q.push_back(v);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_frames(input int target, input int budget, output bit ok);
      int n = 0;
      while (frame_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      ok = (frame_cnt >= target);
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset;
      int p0;
      bit tx_low;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      vectors++; if (TX !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b required 1", TX); end
      vectors++; if (FIFO_Read_EN !== 1'b0) begin miscompares++; $display("FAIL reset_rd: got %b required 0", FIFO_Read_EN); end
      vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b required 0", Busy); end
      vectors++; if (Frame_Done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b required 0", Frame_Done); end
      @(negedge clk);
      rst_n = 1'b1;
      p0 = rd_pulses;
      tx_low = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (TX !== 1'b1) tx_low = 1'b1;
      end
      vectors++; if (rd_pulses != p0) begin miscompares++; $display("FAIL empty_no_read: got %0d pulses required 0", rd_pulses - p0); end
      vectors++; if (tx_low) begin miscompares++; $display("FAIL empty_tx_idle: got low TX required 1"); end
      vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL empty_busy: got %b required 0", Busy); end
   endtask

   task automatic test_single;
      int p0, d0, f0, lat;
      bit ok;
      p0 = rd_pulses; d0 = done_pulses; f0 = frame_cnt;
      push(8'hA5, 1'b1);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (TX !== 1'b0 && lat < 20);
      vectors++; if (lat != LATENCY) begin miscompares++; $display("FAIL start_latency: got %0d required %0d", lat, LATENCY); end
      vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL busy_in_frame: got %b required 1", Busy); end
      wait_frames(f0 + 1, 200, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL single_timeout: got %0d frames required %0d", frame_cnt - f0, 1); end
      vectors++; if (rd_pulses - p0 != 1) begin miscompares++; $display("FAIL single_reads: got %0d required 1", rd_pulses - p0); end
      vectors++; if (done_pulses - d0 != 1) begin miscompares++; $display("FAIL single_done: got %0d required 1", done_pulses - d0); end
      vectors++; if (last_bits !== A5_BITS) begin miscompares++; $display("FAIL a5_sequence: got %b required %b", last_bits, A5_BITS); end
      vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL busy_after: got %b required 0", Busy); end
   endtask

   task automatic test_parity;
      int f0;
      bit ok;
      f0 = frame_cnt;
      push(8'h07, 1'b1);
      wait_frames(f0 + 1, 200, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL parity_timeout: got %0d frames required 1", frame_cnt - f0); end
      vectors++; if (last_bits !== B07_BITS) begin miscompares++; $display("FAIL b07_sequence: got %b required %b", last_bits, B07_BITS); end
`ifdef UART_TX_PARITY_EN
      vectors++; if (last_bits[NB-2] !== 1'b1) begin miscompares++; $display("FAIL parity_07: got %b required 1", last_bits[NB-2]); end
`endif
   endtask

   task automatic test_fill;
      int p0, f0;
      bit ok;
      rst_n = 1'b0;
      p0 = rd_pulses; f0 = frame_cnt;
      for (int i = 1; i <= 32; i++) push(DW'(i), 1'b1);
      vectors++; if (fcount != 32) begin miscompares++; $display("FAIL fifo_full: got %0d entries required 32", fcount); end
      @(negedge clk);
      rst_n = 1'b1;
      wait_frames(f0 + 32, 3000, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL fill_timeout: got %0d frames required 32", frame_cnt - f0); end
      vectors++; if (rd_pulses - p0 != 32) begin miscompares++; $display("FAIL fill_reads: got %0d required 32", rd_pulses - p0); end
      vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL fill_underflow: got %b required 0", underflow); end
      vectors++; if (fcount != 0) begin miscompares++; $display("FAIL fill_drained: got %0d left required 0", fcount); end
      vectors++; if (sb_q.size() != 0) begin miscompares++; $display("FAIL fill_scoreboard: got %0d pending required 0", sb_q.size()); end
   endtask

   task automatic test_back_to_back;
      int f0, n, gap;
      bit ok;
      f0 = frame_cnt;
      push(8'h5A, 1'b1);
      push(8'h96, 1'b1);
      n = 0;
      while (Frame_Done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      vectors++; if (Frame_Done !== 1'b1) begin miscompares++; $display("FAIL b2b_done_timeout: got %b required 1", Frame_Done); end
      gap = 0;
      do begin
         @(negedge clk);
         gap++;
      end while (TX !== 1'b0 && gap < 20);
      vectors++; if (gap != B2B_GAP) begin miscompares++; $display("FAIL b2b_gap: got %0d required %0d", gap, B2B_GAP); end
      wait_frames(f0 + 2, 200, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_timeout: got %0d frames required 2", frame_cnt - f0); end
      vectors++; if (sb_q.size() != 0) begin miscompares++; $display("FAIL b2b_scoreboard: got %0d pending required 0", sb_q.size()); end
   endtask

   task automatic test_reset_mid_frame;
      int f0, n;
      bit ok;
      mon_en = 1'b0;
      f0 = frame_cnt;
      push(8'h35, 1'b0);
      push(8'hC3, 1'b1);
      n = 0;
      while (TX !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      vectors++; if (TX !== 1'b0) begin miscompares++; $display("FAIL abort_start_timeout: got %b required 0", TX); end
      // Middle of data bit 3 (0x35 bit 3 = 0).
      repeat (CPB + 3 * CPB + 1) @(negedge clk);
      vectors++; if (TX !== 1'b0) begin miscompares++; $display("FAIL abort_bit3: got %b required 0", TX); end
      rst_n = 1'b0;
      #1;
      vectors++; if (TX !== 1'b1) begin miscompares++; $display("FAIL abort_tx: got %b required 1", TX); end
      vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b required 0", Busy); end
      vectors++; if (FIFO_Read_EN !== 1'b0) begin miscompares++; $display("FAIL abort_rd: got %b required 0", FIFO_Read_EN); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      mon_en = 1'b1;
      wait_frames(f0 + 1, 200, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL abort_next_timeout: got %0d frames required 1", frame_cnt - f0); end
      vectors++; if (last_bits[DW:1] !== 8'hC3) begin miscompares++; $display("FAIL abort_next_byte: got %h required c3", last_bits[DW:1]); end
      vectors++; if (fcount != 0) begin miscompares++; $display("FAIL abort_drained: got %0d left required 0", fcount); end
      vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL final_underflow: got %b required 0", underflow); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_parity();
      test_fill();
      test_back_to_back();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
